// File: rtl/packet_dispatcher.sv
// packet_dispatcher
//
// Ingress stage ahead of the classifier. Incoming 5-tuple headers are queued in a
// FIFO and issued to the classifier one at a time with a single-cycle
// cls_input_is_valid pulse. Each lookup is timed from issue until the classifier
// reports idle again; the result carries a 16-bit sequence tag and the latency.
// A watchdog abandons lookups that do not complete within TIMEOUT_CYCLES.
//
// Ports
//   clk, reset              : clock, asynchronous active-high reset
//   in_valid / in_ready     : upstream header handshake (in_ready = !full)
//   in_src_ip .. in_protocol: header fields (32/32/16/16/8 bits)
//   cls_input_is_valid      : one-cycle issue pulse to the classifier
//   cls_src_ip .. cls_protocol : registered header, stable between issues
//   cls_ready_to_process    : classifier idle flag
//   done_valid / done_seq / done_cycles : completion pulse, tag and latency
//   timeout                 : one-cycle watchdog pulse
//   fifo_count              : current FIFO occupancy

module packet_dispatcher #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_src_ip,
  input  logic [31:0]              in_dst_ip,
  input  logic [15:0]              in_src_port,
  input  logic [15:0]              in_dst_port,
  input  logic [7:0]               in_protocol,
  output logic                     cls_input_is_valid,
  output logic [31:0]              cls_src_ip,
  output logic [31:0]              cls_dst_ip,
  output logic [15:0]              cls_src_port,
  output logic [15:0]              cls_dst_port,
  output logic [7:0]               cls_protocol,
  input  logic                     cls_ready_to_process,
  output logic                     done_valid,
  output logic [15:0]              done_seq,
  output logic [31:0]              done_cycles,
  output logic                     timeout,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = 104;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StDone,
    StTimeout
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [HW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  logic [HW-1:0] in_hdr;

  assign in_hdr   = {in_src_ip, in_dst_ip, in_src_port, in_dst_port, in_protocol};
  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_hdr;
    end
  end

  assign fifo_count = count_q;

  // ---------------------------------------------------------------------------
  // Issue / completion FSM
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [31:0]   lat_q, lat_d;
  logic [15:0]   seq_q, seq_d;
  logic [15:0]   done_seq_q, done_seq_d;
  logic [31:0]   done_cycles_q, done_cycles_d;
  logic [HW-1:0] cls_hdr_q, cls_hdr_d;
  logic [31:0]   lat_inc;
  logic          lat_hit;

  // Saturating increment; the watchdog fires long before saturation in practice.
  assign lat_inc = (lat_q == '1) ? lat_q : lat_q + 32'd1;
  assign lat_hit = (lat_q == 32'(TIMEOUT_CYCLES));

  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    seq_d         = seq_q;
    done_seq_d    = done_seq_q;
    done_cycles_d = done_cycles_q;
    cls_hdr_d     = cls_hdr_q;
    pop           = 1'b0;

    case (state_q)
      StIdle: begin
        if ((count_q != '0) && cls_ready_to_process) begin
          pop       = 1'b1;
          cls_hdr_d = mem_q[rd_ptr_q];
          lat_d     = '0;
          state_d   = StIssue;
        end
      end

      StIssue: begin
        lat_d   = lat_inc;
        state_d = StWaitBusy;
      end

      // Wait for the classifier to acknowledge by dropping its ready flag.
      StWaitBusy: begin
        if (lat_hit) begin
          state_d = StTimeout;
        end else begin
          lat_d = lat_inc;
          if (!cls_ready_to_process) begin
            state_d = StWaitDone;
          end
        end
      end

      // Ready returning high marks the end of the lookup.
      StWaitDone: begin
        if (lat_hit) begin
          state_d = StTimeout;
        end else if (cls_ready_to_process) begin
          done_cycles_d = lat_q;
          done_seq_d    = seq_q;
          state_d       = StDone;
        end else begin
          lat_d = lat_inc;
        end
      end

      StDone: begin
        seq_d   = seq_q + 16'd1;
        state_d = StIdle;
      end

      // An abandoned lookup still consumes its sequence tag.
      StTimeout: begin
        seq_d   = seq_q + 16'd1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      lat_q         <= '0;
      seq_q         <= '0;
      done_seq_q    <= '0;
      done_cycles_q <= '0;
      cls_hdr_q     <= '0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      seq_q         <= seq_d;
      done_seq_q    <= done_seq_d;
      done_cycles_q <= done_cycles_d;
      cls_hdr_q     <= cls_hdr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: pulses are decodes of the registered state, so each lasts exactly
  // one cycle and the issue pulse cannot repeat back to back.
  // ---------------------------------------------------------------------------
  assign cls_input_is_valid = (state_q == StIssue);
  assign done_valid         = (state_q == StDone);
  assign timeout            = (state_q == StTimeout);
  assign done_seq           = done_seq_q;
  assign done_cycles        = done_cycles_q;

  assign cls_src_ip   = cls_hdr_q[103:72];
  assign cls_dst_ip   = cls_hdr_q[71:40];
  assign cls_src_port = cls_hdr_q[39:24];
  assign cls_dst_port = cls_hdr_q[23:8];
  assign cls_protocol = cls_hdr_q[7:0];

endmodule

// File: tb/tb_packet_dispatcher.sv
// Directed bench for packet_dispatcher (DEPTH=16, TIMEOUT_CYCLES=8).
// A small classifier model drops ready for a fixed time after each issue;
// cls_stall forces ready low. Inputs are driven and outputs sampled 1 time unit
// after the falling clock edge.

module tb_packet_dispatcher;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO   = 8;
  localparam int          BUSY  = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_src_ip, in_dst_ip;
  logic [15:0] in_src_port, in_dst_port;
  logic [7:0]  in_protocol;
  logic        cls_input_is_valid;
  logic [31:0] cls_src_ip, cls_dst_ip;
  logic [15:0] cls_src_port, cls_dst_port;
  logic [7:0]  cls_protocol;
  logic        cls_ready_to_process;
  logic        done_valid;
  logic [15:0] done_seq;
  logic [31:0] done_cycles;
  logic        timeout;
  logic [4:0]  fifo_count;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  packet_dispatcher #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_src_ip            (in_src_ip),
    .in_dst_ip            (in_dst_ip),
    .in_src_port          (in_src_port),
    .in_dst_port          (in_dst_port),
    .in_protocol          (in_protocol),
    .cls_input_is_valid   (cls_input_is_valid),
    .cls_src_ip           (cls_src_ip),
    .cls_dst_ip           (cls_dst_ip),
    .cls_src_port         (cls_src_port),
    .cls_dst_port         (cls_dst_port),
    .cls_protocol         (cls_protocol),
    .cls_ready_to_process (cls_ready_to_process),
    .done_valid           (done_valid),
    .done_seq             (done_seq),
    .done_cycles          (done_cycles),
    .timeout              (timeout),
    .fifo_count           (fifo_count)
  );

  // Classifier model: ready is low for the BUSY cycles that follow an issue.
  int   busy = 0;
  logic cls_stall = 1'b0;
  assign cls_ready_to_process = (busy == 0) && !cls_stall;

  always @(negedge clk) begin
    if (reset) busy = 0;
    else if (cls_input_is_valid) busy = BUSY;
    else if (busy > 0) busy = busy - 1;
  end

  // Event log of issues, completions and timeouts.
  logic [103:0] iss_q[$];
  logic [15:0]  dseq_q[$];
  logic [31:0]  dcyc_q[$];
  int           tmo_cnt = 0;
  int           dbl_err = 0;
  int           stab_err = 0;
  logic         prev_valid = 1'b0;
  logic [103:0] prev_fields = '0;

  always @(negedge clk) begin
    logic [103:0] cur;
    cur = {cls_src_ip, cls_dst_ip, cls_src_port, cls_dst_port, cls_protocol};
    if (cls_input_is_valid) iss_q.push_back(cur);
    if (cls_input_is_valid && prev_valid) dbl_err++;
    if (!reset && !cls_input_is_valid && (cur != prev_fields)) stab_err++;
    if (done_valid) begin
      dseq_q.push_back(done_seq);
      dcyc_q.push_back(done_cycles);
    end
    if (timeout) tmo_cnt++;
    prev_valid  = cls_input_is_valid;
    prev_fields = cur;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [103:0] hdr(input int i);
    return {32'hC0A80000 + 32'(i), 32'h0A0000F0 + 32'(i), 16'(1000 + i), 16'(2000 + i),
            8'(i + 1)};
  endfunction

  task automatic push_set(input logic [103:0] h);
    {in_src_ip, in_dst_ip, in_src_port, in_dst_port, in_protocol} = h;
    in_valid = 1'b1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic wait_done(input int target, input int bound, input string tag);
    int n;
    n = 0;
    while ((dseq_q.size() < target) && (n < bound)) begin
      cyc();
      n++;
    end
    chk(tag, 128'(dseq_q.size()), 128'(target));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, " fifo_count"}, 128'(fifo_count), 128'(0));
    chk({tag, " cls_valid"}, 128'(cls_input_is_valid), 128'(0));
    chk({tag, " cls_fields"},
        128'({cls_src_ip, cls_dst_ip, cls_src_port, cls_dst_port, cls_protocol}), 128'(0));
    chk({tag, " done_valid"}, 128'(done_valid), 128'(0));
    chk({tag, " done_seq"}, 128'(done_seq), 128'(0));
    chk({tag, " done_cycles"}, 128'(done_cycles), 128'(0));
    chk({tag, " timeout"}, 128'(timeout), 128'(0));
  endtask

  initial begin
    logic [103:0] h;
    int n, acc, db, ib, tb0;

    reset = 1'b1;
    in_valid = 1'b0;
    {in_src_ip, in_dst_ip, in_src_port, in_dst_port, in_protocol} = '0;
    cyc();
    cyc();
    chk_reset_outputs("por");
    reset = 1'b0;
    cyc();

    // ---- Single packet ----
    h = {32'h0A000001, 32'h0A000002, 16'd80, 16'd443, 8'd6};
    push_set(h);                                      // cycle c
    chk("t1 in_ready", 128'(in_ready), 128'(1));
    cyc();                                            // c+1
    in_valid = 1'b0;
    chk("t1 count c+1", 128'(fifo_count), 128'(1));
    chk("t1 no early issue", 128'(cls_input_is_valid), 128'(0));
    cyc();                                            // c+2 = t
    chk("t1 issue c+2", 128'(cls_input_is_valid), 128'(1));
    chk("t1 fields",
        128'({cls_src_ip, cls_dst_ip, cls_src_port, cls_dst_port, cls_protocol}), 128'(h));
    chk("t1 count after pop", 128'(fifo_count), 128'(0));
    cyc();                                            // t+1
    chk("t1 issue width", 128'(cls_input_is_valid), 128'(0));
    n = 1;
    while (!done_valid && (n < 20)) begin
      cyc();
      n++;
    end
    chk("t1 done at t+7", 128'(n), 128'(7));
    chk("t1 done_valid", 128'(done_valid), 128'(1));
    chk("t1 done_seq", 128'(done_seq), 128'(0));
    chk("t1 done_cycles", 128'(done_cycles), 128'(6));
    cyc();
    chk("t1 done width", 128'(done_valid), 128'(0));
    chk("t1 fields held",
        128'({cls_src_ip, cls_dst_ip, cls_src_port, cls_dst_port, cls_protocol}), 128'(h));

    // ---- Full FIFO ----
    do_reset();
    cls_stall = 1'b1;
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      push_set(hdr(i));
      if (i == 16) chk("t2 17th refused", 128'(in_ready), 128'(0));
      if (in_ready) acc++;
      cyc();
    end
    in_valid = 1'b0;
    chk("t2 accepted", 128'(acc), 128'(16));
    chk("t2 fifo_count", 128'(fifo_count), 128'(16));
    chk("t2 in_ready full", 128'(in_ready), 128'(0));
    chk("t2 no issue stalled", 128'(cls_input_is_valid), 128'(0));
    ib = iss_q.size();
    db = dseq_q.size();
    cls_stall = 1'b0;
    wait_done(db + 16, 400, "t2 done count");
    chk("t2 issue count", 128'(iss_q.size() - ib), 128'(16));
    for (int i = 0; i < 16; i++) begin
      if (ib + i < iss_q.size()) chk("t2 issue order", 128'(iss_q[ib + i]), 128'(hdr(i)));
      if (db + i < dseq_q.size()) chk("t2 done_seq", 128'(dseq_q[db + i]), 128'(i));
    end
    chk("t2 fifo drained", 128'(fifo_count), 128'(0));

    // ---- Simultaneous push and pop ----
    do_reset();
    cls_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_set(hdr(20 + i));
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    chk("t3 count pre", 128'(fifo_count), 128'(3));
    ib = iss_q.size();
    db = dseq_q.size();
    push_set(hdr(23));
    cls_stall = 1'b0;
    cyc();
    in_valid = 1'b0;
    chk("t3 count held", 128'(fifo_count), 128'(3));
    chk("t3 issue", 128'(cls_input_is_valid), 128'(1));
    chk("t3 head fields",
        128'({cls_src_ip, cls_dst_ip, cls_src_port, cls_dst_port, cls_protocol}),
        128'(hdr(20)));
    wait_done(db + 4, 200, "t3 done count");
    if (ib + 3 < iss_q.size()) chk("t3 last issued", 128'(iss_q[ib + 3]), 128'(hdr(23)));
    if (db + 3 < dseq_q.size()) chk("t3 last seq", 128'(dseq_q[db + 3]), 128'(3));

    // ---- Watchdog ----
    do_reset();
    db  = dseq_q.size();
    ib  = iss_q.size();
    tb0 = tmo_cnt;
    push_set(hdr(30));
    cyc();
    in_valid = 1'b0;
    cyc();                                            // t
    chk("t4 issue", 128'(cls_input_is_valid), 128'(1));
    cls_stall = 1'b1;
    n = 0;
    while (!timeout && (n < 30)) begin
      cyc();
      n++;
    end
    chk("t4 timeout at t+9", 128'(n), 128'(9));
    chk("t4 no done_valid", 128'(dseq_q.size()), 128'(db));
    push_set(hdr(31));
    cyc();
    in_valid = 1'b0;
    chk("t4 timeout width", 128'(timeout), 128'(0));
    repeat (10) cyc();
    chk("t4 held while not ready", 128'(iss_q.size()), 128'(ib + 1));
    chk("t4 queued", 128'(fifo_count), 128'(1));
    chk("t4 one timeout", 128'(tmo_cnt), 128'(tb0 + 1));
    cls_stall = 1'b0;
    wait_done(db + 1, 50, "t4 done count");
    if (db < dseq_q.size()) begin
      chk("t4 next seq", 128'(dseq_q[db]), 128'(1));
      chk("t4 next cycles", 128'(dcyc_q[db]), 128'(6));
    end
    chk("t4 no extra timeout", 128'(tmo_cnt), 128'(tb0 + 1));

    // ---- Sequence wrap ----
    do_reset();
    force dut.seq_q = 16'hFFFF;
    cyc();
    release dut.seq_q;
    db = dseq_q.size();
    push_set(hdr(40));
    cyc();
    push_set(hdr(41));
    cyc();
    in_valid = 1'b0;
    wait_done(db + 2, 100, "t5 done count");
    if (db + 1 < dseq_q.size()) begin
      chk("t5 seq ffff", 128'(dseq_q[db]), 128'(16'hFFFF));
      chk("t5 seq wrap", 128'(dseq_q[db + 1]), 128'(16'h0000));
    end

    // ---- Reset mid-operation ----
    do_reset();
    db = dseq_q.size();
    ib = iss_q.size();
    for (int i = 0; i < 5; i++) begin
      push_set(hdr(50 + i));
      cyc();
    end
    in_valid = 1'b0;
    cyc();                                            // t+4, WAIT_DONE
    chk("t6 queued", 128'(fifo_count), 128'(4));
    chk("t6 not done yet", 128'(dseq_q.size()), 128'(db));
    reset = 1'b1;
    #1;
    chk_reset_outputs("t6 async");
    cyc();
    cyc();
    reset = 1'b0;
    repeat (20) cyc();
    chk("t6 no done after reset", 128'(dseq_q.size()), 128'(db));
    chk("t6 no reissue", 128'(iss_q.size()), 128'(ib + 1));
    chk("t6 fifo empty", 128'(fifo_count), 128'(0));

    // ---- Whole-run properties ----
    chk("no back-to-back issue", 128'(dbl_err), 128'(0));
    chk("fields stable between issues", 128'(stab_err), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
